uart_tx_arbiter: RTL

Round-robin arbiter and sequencer sharing the single `uart_tx` transmitter between `NUM_REQ` byte producers. Each requester offers bytes over a valid/ready handshake. The block selects one requester, issues exactly one `write_en_i` pulse per byte to `uart_tx`, and waits for the transmitter to drain before accepting the next byte. A requester can lock the transmitter for a multi-byte packet using a `last` flag, and a timeout prevents a stalled owner from holding the lock forever.

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers,
// with per-packet locking and a stalled-owner lock timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic                   tx_busy_i,
    output logic                   tx_write_en_o,
    output logic [7:0]             tx_byte_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   lock_o
);

    localparam int          IW = $clog2(NUM_REQ);
    localparam int          CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam int unsigned NR = NUM_REQ;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;
    logic            r_lock;
    logic            r_we;
    logic [7:0]      r_byte;

    logic [IW-1:0]   w_cand;
    logic            w_cand_vld;
    logic            w_timeout;
    logic            w_accept;

    // Locked: only the owner may be chosen. Unlocked: first valid from ptr+1.
    always_comb begin
        w_cand     = '0;
        w_cand_vld = 1'b0;
        if (r_lock) begin
            w_cand     = r_owner;
            w_cand_vld = req_valid_i[r_owner];
        end else begin
            for (int unsigned i = 1; i <= NR; i++) begin
                if (!w_cand_vld && req_valid_i[IW'((32'(r_ptr) + i) % NR)]) begin
                    w_cand     = IW'((32'(r_ptr) + i) % NR);
                    w_cand_vld = 1'b1;
                end
            end
        end
    end

    // Timeout release takes priority over a same-cycle owner request.
    assign w_timeout = (LOCK_TIMEOUT != 0) && (r_state == S_IDLE) && r_lock &&
                       (r_cnt == CW'(LOCK_TIMEOUT));

    assign w_accept = (r_state == S_IDLE) && !reset_i && w_cand_vld &&
                      !tx_busy_i && !w_timeout;

    always_comb begin
        req_ready_o = '0;
        if (w_accept) begin
            req_ready_o[w_cand] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_HOLD;
            S_HOLD:  w_state_nxt = S_DRAIN;
            S_DRAIN: if (!tx_busy_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_byte  <= '0;
            r_lock  <= 1'b0;
            r_owner <= '0;
            r_ptr   <= IW'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_accept;
            if (w_accept) begin
                r_byte  <= req_data_i[8*w_cand +: 8];
                r_owner <= w_cand;
                if (req_last_i[w_cand]) begin
                    r_lock <= 1'b0;
                    r_ptr  <= w_cand;
                end else begin
                    r_lock <= 1'b1;
                end
            end else if (w_timeout) begin
                r_lock <= 1'b0;
                r_ptr  <= r_owner;
            end
        end
    end

    // Counts IDLE cycles in which a locked owner has nothing to send.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else if (w_accept || w_timeout || (r_state != S_IDLE) || !r_lock) begin
            r_cnt <= '0;
        end else if ((LOCK_TIMEOUT != 0) && !req_valid_i[r_owner]) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        grant_o = '0;
        if ((r_state != S_IDLE) || r_lock) begin
            grant_o[r_owner] = 1'b1;
        end
    end

    assign tx_write_en_o = r_we;
    assign tx_byte_o     = r_byte;
    assign lock_o        = r_lock;

endmodule
